// File: rtl/sram_cfg_pkg.sv
// Shared configuration codes, FSM states, latched-request payload and lane helper
// for the width-configurable SRAM access controller.
package sram_cfg_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANE_W = 8;

    localparam logic [1:0] CONF_X32 = 2'b00;
    localparam logic [1:0] CONF_X16 = 2'b01;
    localparam logic [1:0] CONF_X8  = 2'b10;
    localparam logic [1:0] CONF_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PRE  = 2'b01,
        ACT  = 2'b10,
        RESP = 2'b11
    } state_t;

    // Request fields held for the whole access; the row is kept separately since its width is a parameter.
    typedef struct packed {
        logic              we;
        logic [1:0]        conf;
        logic [1:0]        sel;
        logic [DATA_W-1:0] wdata;
    } req_lat_t;

    // Index of the lowest 8-bit lane occupied by the logical word.
    function automatic logic [1:0] lane_base(input logic [1:0] conf, input logic [1:0] sel);
        case (conf)
            CONF_X16: lane_base = {sel[0], 1'b0};
            CONF_X8:  lane_base = sel;
            default:  lane_base = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/sram_access_ctrl_if.sv
// Request/response bus between the bus adapter (master) and the SRAM access controller (slave).
interface sram_access_ctrl_if #(
    parameter int unsigned ADDR_W = 8
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/bl_mask_8_32_2.sv
// Bitline mask decoder: 1 = bit blocked, 8-bit lanes over a 32-bit row, 2-bit sub-word select.
module bl_mask_8_32_2
    import sram_cfg_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  conf,
    output logic [31:0] mask_c
);

    always_comb begin
        mask_c = '1;
        case (conf)
            CONF_X32: mask_c = '0;
            CONF_X16: mask_c = addr[0] ? 32'h0000_FFFF : 32'hFFFF_0000;
            CONF_X8:  mask_c[{addr, 3'b000} +: 8] = 8'h00;
            default:  mask_c = '1;
        endcase
    end

endmodule

// File: rtl/sram_lane_mux.sv
// Write-data lane replication and right-justified read-lane extraction.
module sram_lane_mux
    import sram_cfg_pkg::*;
(
    input  logic [1:0]        conf,
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] row_rdata,
    output logic [DATA_W-1:0] wdata_c,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted = row_rdata >> {lane_base(conf, sel), 3'b000};
        wdata_c = '0;
        rdata_c = '0;
        case (conf)
            CONF_X32: begin
                wdata_c = wdata;
                rdata_c = row_rdata;
            end
            CONF_X16: begin
                wdata_c = {2{wdata[15:0]}};
                rdata_c = {16'h0000, shifted[15:0]};
            end
            CONF_X8: begin
                wdata_c = {4{wdata[LANE_W-1:0]}};
                rdata_c = {24'h00_0000, shifted[LANE_W-1:0]};
            end
            default: begin
                wdata_c = '0;
                rdata_c = '0;
            end
        endcase
    end

endmodule

// File: rtl/sram_access_ctrl.sv
// Single-access SRAM sequencer: precharge -> wordline/sense -> respond, with
// lane masking and lane muxing for x32/x16/x8 logical words.
module sram_access_ctrl
    import sram_cfg_pkg::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned SENSE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           cfg_conf,
    sram_access_ctrl_if.slave    bus,
    output logic                 sram_pre,
    output logic                 sram_wl_en,
    output logic                 sram_we,
    output logic [ADDR_W-1:0]    sram_row,
    output logic [DATA_W-1:0]    sram_bl_mask,
    output logic [DATA_W-1:0]    sram_wdata,
    input  logic [DATA_W-1:0]    sram_rdata
);

    localparam int unsigned CNT_W = $clog2(SENSE_CYCLES + 1);

    state_t            state;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_d;
    req_lat_t          lat;
    logic [ADDR_W-1:0] row_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              ready_q;
    logic              accept;
    logic              last_act;
    logic [DATA_W-1:0] mask_raw;
    logic [DATA_W-1:0] rd_lane;

    assign accept   = bus.req_valid && ready_q;
    assign last_act = (state == ACT) && (cnt == CNT_W'(1));

    // Next-state and wordline counter.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: if (accept) state_d = (cfg_conf == CONF_ILL) ? RESP : PRE;
            PRE: begin
                state_d = ACT;
                cnt_d   = CNT_W'(SENSE_CYCLES);
            end
            ACT: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_d = RESP;
            end
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is registered so it stays low for the whole time reset is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            lat     <= '0;
            row_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            ready_q <= (state_d == IDLE);
            if (accept) begin
                lat     <= '{we: bus.req_we, conf: cfg_conf, sel: bus.req_addr[1:0], wdata: bus.req_wdata};
                row_q   <= bus.req_addr[ADDR_W+1:2];
                rdata_q <= '0;
                err_q   <= (cfg_conf == CONF_ILL);
            end
            if (last_act && !lat.we) rdata_q <= rd_lane;
        end
    end

    bl_mask_8_32_2 u_mask (
        .addr   (lat.sel),
        .conf   (lat.conf),
        .mask_c (mask_raw)
    );

    sram_lane_mux u_lane_mux (
        .conf      (lat.conf),
        .sel       (lat.sel),
        .wdata     (lat.wdata),
        .row_rdata (sram_rdata),
        .wdata_c   (sram_wdata),
        .rdata_c   (rd_lane)
    );

    assign sram_pre     = (state == PRE);
    assign sram_wl_en   = (state == ACT);
    assign sram_we      = (state == ACT) && lat.we;
    assign sram_row     = row_q;
    assign sram_bl_mask = ((state == PRE) || (state == ACT)) ? mask_raw : '1;

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl (SENSE_CYCLES=2): phase timing, masks, lane mux,
// error path, response back-pressure and mid-access reset.
module tb_sram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  cfg_conf = 2'b00;
    logic        sram_pre;
    logic        sram_wl_en;
    logic        sram_we;
    logic [7:0]  sram_row;
    logic [31:0] sram_bl_mask;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    sram_access_ctrl_if #(.ADDR_W(8)) bus ();

    sram_access_ctrl #(.ADDR_W(8), .SENSE_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_conf     (cfg_conf),
        .bus          (bus),
        .sram_pre     (sram_pre),
        .sram_wl_en   (sram_wl_en),
        .sram_we      (sram_we),
        .sram_row     (sram_row),
        .sram_bl_mask (sram_bl_mask),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    always #5 clk = ~clk;

    // Stimulus only: present a request; accepted on the next rising edge if ready.
    task automatic put_req(input logic we, input logic [1:0] conf, input logic [9:0] addr, input logic [31:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        cfg_conf      = conf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", bus.req_ready); end
        n_cmp++; if ({sram_pre, sram_wl_en, sram_we} !== 3'b000) begin n_bad++; $display("FAIL rst_ctl: got %b want 000", {sram_pre, sram_wl_en, sram_we}); end
        n_cmp++; if (sram_bl_mask !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rst_mask: got %h want ffffffff", sram_bl_mask); end
        n_cmp++; if (sram_row !== 8'h00) begin n_bad++; $display("FAIL rst_row: got %h want 00", sram_row); end
        n_cmp++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== 34'h0) begin n_bad++; $display("FAIL rst_rsp: got %b %b %h want 0 0 0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_x32_write();
        put_req(1'b1, 2'b00, {8'd5, 2'b00}, 32'hDEAD_BEEF);
        @(negedge clk); bus.req_valid = 1'b0;
        n_cmp++; if ({sram_pre, sram_wl_en, sram_we} !== 3'b100) begin n_bad++; $display("FAIL w32_pre: got %b want 100", {sram_pre, sram_wl_en, sram_we}); end
        n_cmp++; if (sram_bl_mask !== 32'h0) begin n_bad++; $display("FAIL w32_mask: got %h want 00000000", sram_bl_mask); end
        n_cmp++; if (sram_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL w32_wdata: got %h want deadbeef", sram_wdata); end
        n_cmp++; if (sram_row !== 8'd5) begin n_bad++; $display("FAIL w32_row: got %h want 05", sram_row); end
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL w32_busy: got %b want 0", bus.req_ready); end
        @(negedge clk);
        n_cmp++; if ({sram_pre, sram_wl_en, sram_we} !== 3'b011) begin n_bad++; $display("FAIL w32_act1: got %b want 011", {sram_pre, sram_wl_en, sram_we}); end
        @(negedge clk);
        n_cmp++; if ({sram_pre, sram_wl_en, sram_we, bus.rsp_valid} !== 4'b0110) begin n_bad++; $display("FAIL w32_act2: got %b want 0110", {sram_pre, sram_wl_en, sram_we, bus.rsp_valid}); end
        @(negedge clk);
        n_cmp++; if ({bus.rsp_valid, bus.rsp_err, sram_wl_en} !== 3'b100) begin n_bad++; $display("FAIL w32_rsp: got %b want 100", {bus.rsp_valid, bus.rsp_err, sram_wl_en}); end
        n_cmp++; if (bus.rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL w32_rdata: got %h want 0", bus.rsp_rdata); end
        n_cmp++; if (sram_bl_mask !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL w32_mask_idle: got %h want ffffffff", sram_bl_mask); end
        bus.rsp_ready = 1'b1;
        @(negedge clk); bus.rsp_ready = 1'b0;
        n_cmp++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin n_bad++; $display("FAIL w32_done: got %b want 01", {bus.rsp_valid, bus.req_ready}); end
    endtask

    task automatic test_reads();
        // x8 read row 3, sel 2
        put_req(1'b0, 2'b10, {8'd3, 2'b10}, 32'h0);
        @(negedge clk); bus.req_valid = 1'b0;
        n_cmp++; if (sram_bl_mask !== 32'hFF00_FFFF) begin n_bad++; $display("FAIL r8_mask: got %h want ff00ffff", sram_bl_mask); end
        n_cmp++; if (sram_row !== 8'd3) begin n_bad++; $display("FAIL r8_row: got %h want 03", sram_row); end
        @(negedge clk); sram_rdata = 32'h4433_2211;
        n_cmp++; if ({sram_wl_en, sram_we} !== 2'b10) begin n_bad++; $display("FAIL r8_act: got %b want 10", {sram_wl_en, sram_we}); end
        repeat (2) @(negedge clk);
        n_cmp++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b10, 32'h0000_0033}) begin n_bad++; $display("FAIL r8_rsp: got %b %b %h want 1 0 00000033", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
        bus.rsp_ready = 1'b1;
        @(negedge clk); bus.rsp_ready = 1'b0;
        // x16 read row 1, sel 0
        put_req(1'b0, 2'b01, {8'd1, 2'b00}, 32'h0);
        @(negedge clk); bus.req_valid = 1'b0;
        n_cmp++; if (sram_bl_mask !== 32'hFFFF_0000) begin n_bad++; $display("FAIL r16_mask: got %h want ffff0000", sram_bl_mask); end
        repeat (3) @(negedge clk);
        n_cmp++; if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 32'h0000_2211}) begin n_bad++; $display("FAIL r16_rsp: got %b %h want 1 00002211", bus.rsp_valid, bus.rsp_rdata); end
        bus.rsp_ready = 1'b1;
        @(negedge clk); bus.rsp_ready = 1'b0;
        // x32 read row 2
        put_req(1'b0, 2'b00, {8'd2, 2'b11}, 32'h0);
        repeat (4) @(negedge clk); bus.req_valid = 1'b0;
        n_cmp++; if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 32'h4433_2211}) begin n_bad++; $display("FAIL r32_rsp: got %b %h want 1 44332211", bus.rsp_valid, bus.rsp_rdata); end
        bus.rsp_ready = 1'b1;
        @(negedge clk); bus.rsp_ready = 1'b0;
    endtask

    task automatic test_narrow_writes();
        put_req(1'b1, 2'b01, {8'd7, 2'b01}, 32'h0000_ABCD);
        @(negedge clk); bus.req_valid = 1'b0;
        n_cmp++; if (sram_wdata !== 32'hABCD_ABCD) begin n_bad++; $display("FAIL w16_wdata: got %h want abcdabcd", sram_wdata); end
        n_cmp++; if (sram_bl_mask !== 32'h0000_FFFF) begin n_bad++; $display("FAIL w16_mask: got %h want 0000ffff", sram_bl_mask); end
        @(negedge clk);
        n_cmp++; if ({sram_wl_en, sram_we} !== 2'b11) begin n_bad++; $display("FAIL w16_we: got %b want 11", {sram_wl_en, sram_we}); end
        repeat (2) @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(negedge clk); bus.rsp_ready = 1'b0;
        put_req(1'b1, 2'b10, {8'd8, 2'b01}, 32'h1234_565A);
        @(negedge clk); bus.req_valid = 1'b0;
        n_cmp++; if (sram_wdata !== 32'h5A5A_5A5A) begin n_bad++; $display("FAIL w8_wdata: got %h want 5a5a5a5a", sram_wdata); end
        n_cmp++; if (sram_bl_mask !== 32'hFFFF_00FF) begin n_bad++; $display("FAIL w8_mask: got %h want ffff00ff", sram_bl_mask); end
        repeat (3) @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(negedge clk); bus.rsp_ready = 1'b0;
    endtask

    task automatic test_illegal_conf();
        put_req(1'b0, 2'b11, {8'd4, 2'b00}, 32'h0);
        @(negedge clk); bus.req_valid = 1'b0;
        n_cmp++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b11, 32'h0}) begin n_bad++; $display("FAIL ill_rsp: got %b %b %h want 1 1 0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
        n_cmp++; if ({sram_pre, sram_wl_en, sram_bl_mask} !== {2'b00, 32'hFFFF_FFFF}) begin n_bad++; $display("FAIL ill_sram: got %b %b %h want 0 0 ffffffff", sram_pre, sram_wl_en, sram_bl_mask); end
        bus.rsp_ready = 1'b1;
        @(negedge clk); bus.rsp_ready = 1'b0;
        n_cmp++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin n_bad++; $display("FAIL ill_done: got %b want 01", {bus.rsp_valid, bus.req_ready}); end
    endtask

    task automatic test_back_to_back();
        sram_rdata = 32'hA1B2_C3D4;
        put_req(1'b0, 2'b10, {8'd2, 2'b11}, 32'h0);
        @(negedge clk); bus.req_valid = 1'b0; cfg_conf = 2'b11;
        @(negedge clk); cfg_conf = 2'b01;
        n_cmp++; if (sram_bl_mask !== 32'h00FF_FFFF) begin n_bad++; $display("FAIL b2b_mask: got %h want 00ffffff", sram_bl_mask); end
        repeat (2) @(negedge clk);
        // next request waits while the response is stalled
        put_req(1'b1, 2'b00, {8'd9, 2'b00}, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.req_ready} !== {2'b10, 32'h0000_00A1, 1'b0}) begin n_bad++; $display("FAIL b2b_hold%0d: got %b %b %h %b want 1 0 000000a1 0", i, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.req_ready); end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk); bus.rsp_ready = 1'b0;
        n_cmp++; if ({bus.rsp_valid, bus.req_ready, sram_pre} !== 3'b010) begin n_bad++; $display("FAIL b2b_gap: got %b want 010", {bus.rsp_valid, bus.req_ready, sram_pre}); end
        @(negedge clk); bus.req_valid = 1'b0;
        n_cmp++; if ({sram_pre, sram_row, sram_wdata, sram_bl_mask} !== {1'b1, 8'd9, 32'h1234_5678, 32'h0}) begin n_bad++; $display("FAIL b2b_next: got %b %h %h %h want 1 09 12345678 00000000", sram_pre, sram_row, sram_wdata, sram_bl_mask); end
        repeat (3) @(negedge clk);
        n_cmp++; if ({bus.rsp_valid, bus.rsp_err} !== 2'b10) begin n_bad++; $display("FAIL b2b_rsp2: got %b want 10", {bus.rsp_valid, bus.rsp_err}); end
        bus.rsp_ready = 1'b1;
        @(negedge clk); bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        put_req(1'b1, 2'b00, {8'd4, 2'b00}, 32'hCAFE_F00D);
        @(negedge clk); bus.req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (sram_wl_en !== 1'b1) begin n_bad++; $display("FAIL rma_act: got %b want 1", sram_wl_en); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({sram_wl_en, sram_we, bus.rsp_valid, bus.req_ready} !== 4'b0000) begin n_bad++; $display("FAIL rma_abort: got %b want 0000", {sram_wl_en, sram_we, bus.rsp_valid, bus.req_ready}); end
        n_cmp++; if ({sram_bl_mask, sram_row} !== {32'hFFFF_FFFF, 8'h00}) begin n_bad++; $display("FAIL rma_mask: got %h %h want ffffffff 00", sram_bl_mask, sram_row); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus.req_ready, bus.rsp_valid, sram_wl_en} !== 3'b100) begin n_bad++; $display("FAIL rma_release: got %b want 100", {bus.req_ready, bus.rsp_valid, sram_wl_en}); end
        put_req(1'b0, 2'b11, {8'd1, 2'b00}, 32'h0);
        @(negedge clk); bus.req_valid = 1'b0;
        n_cmp++; if ({bus.rsp_valid, bus.rsp_err} !== 2'b11) begin n_bad++; $display("FAIL rma_after: got %b want 11", {bus.rsp_valid, bus.rsp_err}); end
        bus.rsp_ready = 1'b1;
        @(negedge clk); bus.rsp_ready = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_x32_write();
        test_reads();
        test_narrow_writes();
        test_illegal_conf();
        test_back_to_back();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
